serial_word_tx: RTL and testbench

- Native-RTL UART transmitter for the fabric side of the RS232 serial link.
- Accepts 32-bit messages through a Bluespec-style put interface (EN/RDY) and buffers them in a 2-entry FIFO.
- Sends each message as 4 bytes, LSB byte first, 8N1 framing, on the UART sout pin.
- Honours the host's ctsN flow control at byte boundaries. It is the transmit end opposite the receiver that delivers 32-bit messages from the UART.

---
 rtl/serial_word_tx_if.sv | 18 +
 rtl/serial_word_tx.sv | 176 +++++++++++++++++
 tb/tb_serial_word_tx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_tx_if.sv
// rtl/serial_word_tx_if.sv - put-side handshake bundle for the serial word transmitter
interface serial_word_tx_if;
  logic [31:0] msg_put_pin;
  logic        EN_msg_put_pin;
  logic        RDY_msg_put_pin;

  modport master (
    output msg_put_pin,
    output EN_msg_put_pin,
    input  RDY_msg_put_pin
  );

  modport slave (
    input  msg_put_pin,
    input  EN_msg_put_pin,
    output RDY_msg_put_pin
  );
endinterface

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - 32-bit word to 8N1 UART transmitter with 2-deep FIFO and CTS gating
module serial_word_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit USE_CTS      = 1'b1
) (
  input  logic               sys_clk_pin,
  input  logic               sys_rst_pin,
  serial_word_tx_if.slave    bus,
  output logic               uart_sout_pin,
  input  logic               uart_ctsN_pin,
  output logic               tx_busy_pin,
  output logic [15:0]        words_sent_pin
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [15:0] baud;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  shift;
  logic        sout;
  logic [15:0] words_sent;

  logic [31:0] mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        cts_sync1;
  logic        cts_sync2;
  logic        cts_ok;

  logic        push;
  logic        pop;
  logic        baud_last;
  logic [31:0] head;
  logic [31:0] next_head;
  logic        next_avail;

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  assign bus.RDY_msg_put_pin = (count != 2'd2) && !sys_rst_pin;
  assign push       = bus.EN_msg_put_pin && bus.RDY_msg_put_pin;
  assign baud_last  = (baud == BAUD_LAST);
  assign pop        = (state == STOP) && baud_last && (byte_idx == 2'd3);
  assign head       = mem[rd_ptr];
  // The word following the head: already queued, or arriving on this very edge.
  assign next_head  = (count == 2'd2) ? mem[~rd_ptr] : bus.msg_put_pin;
  assign next_avail = (count == 2'd2) || push;
  assign cts_ok     = USE_CTS ? ~cts_sync2 : 1'b1;

  assign uart_sout_pin  = sout;
  assign tx_busy_pin    = (count != 2'd0) || (state != IDLE);
  assign words_sent_pin = words_sent;

  // Two-flop synchronizer for the asynchronous active-low clear-to-send.
  always_ff @(posedge sys_clk_pin) begin
    if (sys_rst_pin) begin
      cts_sync1 <= 1'b1;
      cts_sync2 <= 1'b1;
    end else begin
      cts_sync1 <= uart_ctsN_pin;
      cts_sync2 <= cts_sync1;
    end
  end

  // Two-entry FIFO; the head is released only after its last stop bit.
  always_ff @(posedge sys_clk_pin) begin
    if (sys_rst_pin) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.msg_put_pin;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Framing FSM with registered serial output: start, 8 data LSB-first, stop per byte.
  always_ff @(posedge sys_clk_pin) begin
    if (sys_rst_pin) begin
      state      <= IDLE;
      baud       <= 16'd0;
      bit_idx    <= 3'd0;
      byte_idx   <= 2'd0;
      shift      <= 8'd0;
      sout       <= 1'b1;
      words_sent <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          baud <= 16'd0;
          if ((count != 2'd0) && cts_ok) begin
            shift <= get_byte(head, byte_idx);
            sout  <= 1'b0;
            state <= START;
          end else begin
            sout <= 1'b1;
          end
        end
        START: begin
          if (baud_last) begin
            baud    <= 16'd0;
            bit_idx <= 3'd0;
            sout    <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud <= 16'd0;
            if (bit_idx == 3'd7) begin
              sout  <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              sout    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud <= 16'd0;
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              if (cts_ok) begin
                shift <= get_byte(head, byte_idx + 2'd1);
                sout  <= 1'b0;
                state <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              byte_idx   <= 2'd0;
              words_sent <= words_sent + 16'd1;
              if (next_avail && cts_ok) begin
                shift <= next_head[7:0];
                sout  <= 1'b0;
                state <= START;
              end else begin
                state <= IDLE;
              end
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          sout  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - directed self-checking bench for serial_word_tx
module tb_serial_word_tx;

  logic        clk;
  logic        rst;
  logic        ctsN;
  logic        sout;
  logic        busy;
  logic [15:0] ws;
  int          total;
  int          bad;

  serial_word_tx_if bus();

  serial_word_tx #(.CLKS_PER_BIT(4), .USE_CTS(1'b1)) dut (
    .sys_clk_pin    (clk),
    .sys_rst_pin    (rst),
    .bus            (bus),
    .uart_sout_pin  (sout),
    .uart_ctsN_pin  (ctsN),
    .tx_busy_pin    (busy),
    .words_sent_pin (ws)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller sits in the first cycle of a start bit; samples first and last cycle of every bit.
  task automatic recv_byte(input logic [7:0] b, input string tag, input bit put_last, input logic [31:0] w);
    logic [9:0] exp;
    logic [9:0] first;
    logic [9:0] last;
    exp = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      first[i] = sout;
      cycles(3);
      last[i] = sout;
      if (put_last && i == 9) begin
        bus.EN_msg_put_pin = 1'b1;
        bus.msg_put_pin    = w;
      end
      cycles(1);
      if (put_last && i == 9) bus.EN_msg_put_pin = 1'b0;
    end
    check({22'd0, first}, {22'd0, exp}, {tag, "_bitstart"});
    check({22'd0, last}, {22'd0, exp}, {tag, "_bitend"});
  endtask

  task automatic recv_word(input logic [31:0] w, input string tag);
    for (int b = 0; b < 4; b++)
      recv_byte(w[b*8 +: 8], $sformatf("%s_b%0d", tag, b), 1'b0, 32'd0);
  endtask

  task automatic put(input logic [31:0] w);
    bus.EN_msg_put_pin = 1'b1;
    bus.msg_put_pin    = w;
    cycles(1);
    bus.EN_msg_put_pin = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ctsN  = 1'b0;
    bus.EN_msg_put_pin = 1'b0;
    bus.msg_put_pin    = 32'd0;

    // reset state
    cycles(3);
    check(sout, 1, "rst_sout");
    check(bus.RDY_msg_put_pin, 0, "rst_rdy");
    check(busy, 0, "rst_busy");
    check(ws, 0, "rst_ws");
    rst = 1'b0;
    cycles(1);
    check(bus.RDY_msg_put_pin, 1, "post_rst_rdy");
    check(sout, 1, "post_rst_sout");
    cycles(4);

    // single word, start bit at n+2
    put(32'hA5C3_0F81);
    check(sout, 1, "sw_n1_sout");
    check(busy, 1, "sw_busy");
    cycles(1);
    recv_word(32'hA5C3_0F81, "sw");
    check(ws, 1, "sw_ws");
    check(busy, 0, "sw_busy_end");
    check(sout, 1, "sw_idle");

    // three puts back to back: third is refused, two words with no gap
    bus.EN_msg_put_pin = 1'b1;
    bus.msg_put_pin    = 32'h1111_2222;
    cycles(1);
    bus.msg_put_pin    = 32'h3333_4444;
    cycles(1);
    check(bus.RDY_msg_put_pin, 0, "full_rdy");
    check(sout, 0, "full_start");
    bus.msg_put_pin    = 32'hDEAD_DEAD;
    fork begin cycles(1); bus.EN_msg_put_pin = 1'b0; end join_none
    recv_word(32'h1111_2222, "full_w1");
    recv_word(32'h3333_4444, "full_w2");
    check(ws, 3, "full_ws");
    check(busy, 0, "full_busy");
    cycles(12);
    check(sout, 1, "full_no_third");

    // flow control
    ctsN = 1'b1;
    cycles(3);
    put(32'h1234_5678);
    cycles(20);
    check(sout, 1, "fc_hold");
    check(busy, 1, "fc_busy");
    ctsN = 1'b0;
    cycles(2);
    check(sout, 1, "fc_sync_lat");
    cycles(1);
    check(sout, 0, "fc_start");
    recv_byte(8'h78, "fc_b0", 1'b0, 32'd0);
    fork begin cycles(8); ctsN = 1'b1; end join_none
    recv_byte(8'h56, "fc_b1", 1'b0, 32'd0);
    check(sout, 1, "fc_paused");
    cycles(20);
    check(sout, 1, "fc_paused_long");
    ctsN = 1'b0;
    cycles(2);
    check(sout, 1, "fc_resume_lat");
    cycles(1);
    recv_byte(8'h34, "fc_b2", 1'b0, 32'd0);
    recv_byte(8'h12, "fc_b3", 1'b0, 32'd0);
    check(ws, 4, "fc_ws");

    // refill when RDY rises after a pop, ordering A, B, C
    bus.EN_msg_put_pin = 1'b1;
    bus.msg_put_pin    = 32'hAAAA_0001;
    cycles(1);
    bus.msg_put_pin    = 32'hBBBB_0002;
    cycles(1);
    bus.EN_msg_put_pin = 1'b0;
    recv_word(32'hAAAA_0001, "pp_a");
    check(bus.RDY_msg_put_pin, 1, "pp_rdy_rise");
    bus.EN_msg_put_pin = 1'b1;
    bus.msg_put_pin    = 32'hCCCC_0003;
    fork begin
      cycles(1);
      bus.EN_msg_put_pin = 1'b0;
      check(bus.RDY_msg_put_pin, 0, "pp_count2");
    end join_none
    recv_word(32'hBBBB_0002, "pp_b");
    recv_word(32'hCCCC_0003, "pp_c");
    check(ws, 7, "pp_ws");

    // put on the exact pop edge with one word queued: next word follows with no gap
    put(32'h0D0C_0B0A);
    cycles(1);
    recv_byte(8'h0A, "sp_b0", 1'b0, 32'd0);
    recv_byte(8'h0B, "sp_b1", 1'b0, 32'd0);
    recv_byte(8'h0C, "sp_b2", 1'b0, 32'd0);
    recv_byte(8'h0D, "sp_b3", 1'b1, 32'h5A5A_C3C3);
    check(busy, 1, "sp_busy");
    check(bus.RDY_msg_put_pin, 1, "sp_rdy_count1");
    recv_word(32'h5A5A_C3C3, "sp_e");
    check(ws, 9, "sp_ws");
    check(busy, 0, "sp_busy_end");

    // reset in the middle of byte 2 data
    put(32'hDEAD_BEEF);
    cycles(91);
    rst = 1'b1;
    cycles(1);
    check(sout, 1, "mr_sout");
    check(bus.RDY_msg_put_pin, 0, "mr_rdy");
    check(busy, 0, "mr_busy");
    check(ws, 0, "mr_ws");
    cycles(1);
    rst = 1'b0;
    cycles(1);
    check(bus.RDY_msg_put_pin, 1, "mr_rdy_after");
    check(sout, 1, "mr_sout_after");
    cycles(3);
    put(32'h0000_0001);
    cycles(1);
    recv_word(32'h0000_0001, "mr_new");
    check(ws, 1, "mr_ws_new");

    // words_sent wraps on the pop
    force dut.words_sent = 16'hFFFF;
    cycles(1);
    release dut.words_sent;
    check(ws, 16'hFFFF, "wrap_pre");
    put(32'h8000_0080);
    cycles(1);
    recv_byte(8'h80, "wrap_b0", 1'b0, 32'd0);
    recv_byte(8'h00, "wrap_b1", 1'b0, 32'd0);
    recv_byte(8'h00, "wrap_b2", 1'b0, 32'd0);
    check(ws, 16'hFFFF, "wrap_hold");
    recv_byte(8'h80, "wrap_b3", 1'b0, 32'd0);
    check(ws, 0, "wrap_ws");
    check(busy, 0, "wrap_busy");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
